// File: rtl/ram_pkg.sv
// Shared definitions for the RAM port B reader slice.
// - RAM_ADDR_W / RAM_DATA_W : geometry of RAM port B
// - reader_state_t          : scan controller states
package ram_pkg;

    localparam int unsigned RAM_ADDR_W = 12;
    localparam int unsigned RAM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } reader_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO holding the reader's output words.
// Ports:
//   clk, rst (async, active-low)   clock / reset
//   flush                          empty the FIFO (pointers and count cleared)
//   push, push_data                write one word
//   pop, pop_data                  remove head word; pop_data is the current head
//   full, empty, count             occupancy status
// Push and pop in the same cycle are both honoured, including when full.
module sync_fifo #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH),
    localparam int unsigned CNT_W     = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == CNT_W'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Storage is reset so the head reads as zero out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ram_port_b_reader.sv
// Scan initiator for RAM read port B. Reads word_count consecutive words
// starting at base_addr and streams them out over valid/ready.
// Ports:
//   clk, rst (async, active-low)        clock / reset
//   start, base_addr, word_count        scan request (ignored while busy)
//   abort                               cancel current scan, no done pulse
//   ain_PORT_B, rq_PORT_B, dout_PORT_B  RAM port B (data returns one cycle after rq)
//   out_data, out_valid, out_ready      output stream
//   busy, done                          scan in progress / completion pulse
// Reads are only issued when the output FIFO is guaranteed space for the
// returning word, so the FIFO can never overflow.
module ram_port_b_reader
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_W     = RAM_ADDR_W,
    parameter int unsigned DATA_W     = RAM_DATA_W,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] word_count,
    input  logic              abort,
    output logic [ADDR_W-1:0] ain_PORT_B,
    output logic              rq_PORT_B,
    input  logic [DATA_W-1:0] dout_PORT_B,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    reader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] remaining_q;
    logic              rq_q;
    logic              inflight_q;
    logic              done_q;
    logic [ADDR_W-1:0] ain_q;

    logic              issue;
    logic              load;
    logic              done_d;
    logic              can_issue;
    logic [CNT_W:0]    occupied;

    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    assign pop = out_valid && out_ready;

    // Words owed to the FIFO: stored, returning this cycle (inflight) and
    // requested last cycle (rq). A pop this cycle frees one slot in time.
    always_comb begin
        occupied = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(rq_q)
                 + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
        can_issue = (occupied < (CNT_W+1)'(FIFO_DEPTH)) && !(fifo_full && !pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The accepting cycle in IDLE also issues the first read, so the first
    // rq appears one cycle after start.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        load    = 1'b0;
        done_d  = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (word_count != '0) begin
                            load    = 1'b1;
                            issue   = 1'b1;
                            state_d = (word_count == ADDR_W'(1)) ? DRAIN : RUN;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (can_issue) begin
                        issue = 1'b1;
                        if (remaining_q == ADDR_W'(1)) begin
                            state_d = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (fifo_empty && !rq_q && !inflight_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q      <= '0;
            remaining_q <= '0;
            rq_q        <= 1'b0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
            ain_q       <= '0;
        end else begin
            rq_q       <= issue;
            inflight_q <= rq_q && !abort;
            done_q     <= done_d;
            if (load) begin
                ain_q       <= base_addr;
                addr_q      <= base_addr + ADDR_W'(1);
                remaining_q <= word_count - ADDR_W'(1);
            end else if (issue) begin
                ain_q       <= addr_q;
                addr_q      <= addr_q + ADDR_W'(1);
                remaining_q <= remaining_q - ADDR_W'(1);
            end
        end
    end

    sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (abort),
        .push      (inflight_q && !abort),
        .push_data (dout_PORT_B),
        .pop       (pop),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign ain_PORT_B = ain_q;
    assign rq_PORT_B  = rq_q;
    assign out_valid  = !fifo_empty;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;

endmodule

// File: tb/tb_ram_port_b_reader.sv
module tb_ram_port_b_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b0;
    logic [11:0] base_addr = '0;
    logic [11:0] word_count = '0;
    logic [11:0] ain;
    logic        rq;
    logic [15:0] dout = '0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    ram_port_b_reader #(
        .ADDR_W     (12),
        .DATA_W     (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .word_count  (word_count),
        .abort       (abort),
        .ain_PORT_B  (ain),
        .rq_PORT_B   (rq),
        .dout_PORT_B (dout),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done)
    );

    // RAM model: data one cycle after the read strobe, garbage otherwise.
    logic [15:0] mem [4096];
    always @(posedge clk) dout <= rq ? mem[ain] : 16'($urandom);

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [11:0] rq_addr_q[$];
    int          rq_cyc_q[$];
    logic [15:0] got_q[$];
    int          done_cnt = 0;
    int          stab_viol = 0;
    logic        prev_v = 1'b0;
    logic        prev_r = 1'b0;
    logic [15:0] prev_d = '0;

    always @(negedge clk) begin
        if (!rst) begin
            prev_v = 1'b0;
        end else begin
            if (rq) begin
                rq_addr_q.push_back(ain);
                rq_cyc_q.push_back(cyc);
            end
            if (out_valid && out_ready) got_q.push_back(out_data);
            if (done) done_cnt++;
            if (prev_v && !prev_r && (!out_valid || out_data !== prev_d)) stab_viol++;
            prev_v = out_valid;
            prev_r = out_ready;
            prev_d = out_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        rq_addr_q.delete();
        rq_cyc_q.delete();
        got_q.delete();
        done_cnt = 0;
    endtask

    task automatic start_scan(input logic [11:0] b, input logic [11:0] c);
        @(posedge clk); #1;
        base_addr  = b;
        word_count = c;
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        base_addr  = $urandom;
        word_count = $urandom;
    endtask

    task automatic wait_done(input int max, input bit rnd, output bit seen, output logic busy_at);
        seen    = 1'b0;
        busy_at = 1'bx;
        for (int i = 0; i < max && !seen; i++) begin
            @(posedge clk); #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (done) begin
                seen    = 1'b1;
                busy_at = busy;
            end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    // Reference: a scan of c words from b yields mem[(b+i) mod 4096], in order.
    task automatic check_scan(input logic [11:0] b, input int c);
        int n;
        logic [11:0] a;
        chk("n_rq", 32'(rq_addr_q.size()), 32'(c));
        chk("n_words", 32'(got_q.size()), 32'(c));
        chk("n_done", 32'(done_cnt), 32'd1);
        n = (got_q.size() < c) ? got_q.size() : c;
        if (rq_addr_q.size() < n) n = rq_addr_q.size();
        for (int i = 0; i < n; i++) begin
            a = 12'((int'(b) + i) % 4096);
            chk("rq_addr", 32'(rq_addr_q[i]), 32'(a));
            chk("word", 32'(got_q[i]), 32'(mem[a]));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ain"}, 32'(ain), 32'd0);
        chk({tag, "_rq"}, 32'(rq), 32'd0);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_data"}, 32'(out_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        bit          seen;
        logic        bz;
        logic [11:0] b;
        int          c;
        int          n_got;
        int          n_rq;

        for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);

        // Reset state
        #1;
        check_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_no_rq", 32'(rq_addr_q.size()), 32'd0);

        // Basic scan
        mem[12'h010] = 16'hA0A0;
        mem[12'h011] = 16'hA1A1;
        mem[12'h012] = 16'hA2A2;
        mem[12'h013] = 16'hA3A3;
        out_ready = 1'b1;
        clear_logs();
        start_scan(12'h010, 12'd4);
        wait_done(50, 1'b0, seen, bz);
        chk("busy_falls_with_done", 32'(bz), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_scan(12'h010, 4);
        if (rq_cyc_q.size() == 4)
            chk("rq_consecutive", 32'(rq_cyc_q[3] - rq_cyc_q[0]), 32'd3);
        else
            chk("rq_consecutive_count", 32'(rq_cyc_q.size()), 32'd4);

        // Backpressure: only FIFO_DEPTH reads go out while the consumer stalls
        out_ready = 1'b0;
        clear_logs();
        b = 12'($urandom);
        start_scan(b, 12'd8);
        repeat (20) @(posedge clk);
        #1;
        chk("bp_rq_count", 32'(rq_addr_q.size()), 32'd4);
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_head", 32'(out_data), 32'(mem[b]));
        chk("bp_busy", 32'(busy), 32'd1);
        out_ready = 1'b1;
        wait_done(100, 1'b0, seen, bz);
        repeat (3) @(posedge clk);
        #1;
        check_scan(b, 8);

        // Address wrap
        clear_logs();
        start_scan(12'hFFE, 12'd4);
        wait_done(50, 1'b0, seen, bz);
        repeat (3) @(posedge clk);
        #1;
        check_scan(12'hFFE, 4);

        // Zero-length scan
        clear_logs();
        start_scan(12'h123, 12'd0);
        @(negedge clk);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("zero_no_rq", 32'(rq_addr_q.size()), 32'd0);
        chk("zero_done_once", 32'(done_cnt), 32'd1);

        // Start while busy is ignored
        clear_logs();
        b = 12'($urandom);
        start_scan(b, 12'd10);
        start_scan(12'($urandom), 12'd5);
        wait_done(300, 1'b1, seen, bz);
        repeat (4) @(posedge clk);
        #1;
        check_scan(b, 10);

        // Random scans with random consumer stalls
        for (int k = 0; k < 6; k++) begin
            clear_logs();
            b = 12'($urandom);
            c = $urandom_range(1, 24);
            start_scan(b, 12'(c));
            wait_done(600, 1'b1, seen, bz);
            repeat (4) @(posedge clk);
            #1;
            check_scan(b, c);
        end

        // Abort two cycles into a long scan
        out_ready = 1'b1;
        clear_logs();
        start_scan(12'($urandom), 12'd16);
        @(posedge clk); #1;
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_rq", 32'(rq), 32'd0);
        n_got = got_q.size();
        n_rq  = rq_addr_q.size();
        repeat (10) @(posedge clk);
        #1;
        chk("abort_no_more_words", 32'(got_q.size()), 32'(n_got));
        chk("abort_no_more_rq", 32'(rq_addr_q.size()), 32'(n_rq));
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        clear_logs();
        b = 12'($urandom);
        start_scan(b, 12'd6);
        wait_done(200, 1'b1, seen, bz);
        repeat (4) @(posedge clk);
        #1;
        check_scan(b, 6);

        // Reset in the middle of a scan
        clear_logs();
        start_scan(12'($urandom), 12'd16);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        n_rq = rq_addr_q.size();
        repeat (8) @(posedge clk);
        #1;
        chk("post_reset_busy", 32'(busy), 32'd0);
        chk("post_reset_valid", 32'(out_valid), 32'd0);
        chk("post_reset_no_rq", 32'(rq_addr_q.size()), 32'(n_rq));
        clear_logs();
        b = 12'($urandom);
        start_scan(b, 12'd5);
        wait_done(200, 1'b0, seen, bz);
        repeat (4) @(posedge clk);
        #1;
        check_scan(b, 5);

        chk("stall_stability", 32'(stab_viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
